// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared types and constants for the RTC bus arbiter
package rtc_bus_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} rtc_state_e;

    localparam int RTC_ADDR_W = 8;
    localparam int RTC_DATA_W = 8;
    localparam logic [7:0] RTC_CMD_ADDR = 8'hF0;

endpackage

// File: rtl/rtc_rr_pick.sv
// rtl/rtc_rr_pick.sv - combinational round-robin picker, one-hot grant
module rtc_rr_pick #(
    parameter int M     = 2,
    parameter int PTR_W = 1
) (
    input  logic [M-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [M-1:0]     gnt_o
);

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        for (int k = M - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % M;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - shares one RTC read/write engine between requesters
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = RTC_ADDR_W,
    parameter int DATA_W    = RTC_DATA_W,
    parameter int START_MAX = 8,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic [DATA_W-1:0]       rdata,
    output logic                    eng_start,
    output logic                    eng_we,
    output logic [ADDR_W-1:0]       eng_addr,
    output logic [DATA_W-1:0]       eng_wdata,
    input  logic                    eng_done,
    input  logic [DATA_W-1:0]       eng_rdata,
    output logic                    busy
);

    localparam int RR_W    = $clog2(N_REQ);
    localparam int MAX_SG  = (START_MAX > GAP_CYC) ? START_MAX : GAP_CYC;
    localparam int CNT_MAX = (TIMEOUT > MAX_SG) ? TIMEOUT : MAX_SG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rtc_state_e          state_q;
    logic [N_REQ-1:0]    gnt_q, done_q;
    logic                err_q, eng_start_q, eng_we_q;
    logic [DATA_W-1:0]   rdata_q, eng_wdata_q;
    logic [ADDR_W-1:0]   eng_addr_q;
    logic [RR_W-1:0]     rr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [N_REQ-2:0]    rr_oh;
    logic [N_REQ-1:0]    win_oh;
    logic [RR_W-1:0]     rr_sub, gnt_idx, rr_next;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // Picker works on lines 1..N_REQ-1 renumbered from 0.
    assign rr_sub = rr_q - RR_W'(1);

    rtc_rr_pick #(
        .M     (N_REQ - 1),
        .PTR_W (RR_W)
    ) u_pick (
        .req_i (req[N_REQ-1:1]),
        .ptr_i (rr_sub),
        .gnt_o (rr_oh)
    );

    always_comb begin
        win_oh    = req[0] ? N_REQ'(1) : {rr_oh, 1'b0};
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
            if (gnt_q[i]) gnt_idx = RR_W'(i);
        end
        rr_next = (gnt_idx == RR_W'(N_REQ - 1)) ? RR_W'(1) : gnt_idx + RR_W'(1);
    end

    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            eng_start_q <= 1'b0;
            eng_we_q    <= 1'b0;
            eng_addr_q  <= '0;
            eng_wdata_q <= '0;
            rr_q        <= RR_W'(1);
            cnt_q       <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|win_oh) begin
                        gnt_q       <= win_oh;
                        eng_we_q    <= win_we;
                        eng_addr_q  <= win_addr;
                        eng_wdata_q <= win_wdata;
                        eng_start_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    cnt_q <= cnt_d;
                    // A real eng_done beats the timeout terminal count.
                    if (eng_done || (state_q == WAIT && cnt_q >= CNT_W'(TIMEOUT - 1))) begin
                        done_q      <= gnt_q;
                        err_q       <= !eng_done;
                        if (eng_done && !eng_we_q) rdata_q <= eng_rdata;
                        if (!gnt_q[0]) rr_q <= rr_next;
                        gnt_q       <= '0;
                        eng_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= GAP;
                    end else if (state_q == ISSUE && cnt_q == CNT_W'(START_MAX - 1)) begin
                        eng_start_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_d;
                    if (cnt_q >= CNT_W'(GAP_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign eng_start = eng_start_q;
    assign eng_we    = eng_we_q;
    assign eng_addr  = eng_addr_q;
    assign eng_wdata = eng_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - self-checking bench for rtc_bus_arbiter
module tb_rtc_bus_arbiter;

    localparam int GAP_CYC = 4;

    typedef struct {
        int         idx;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] rdata;
        logic       err;
        int         done_lat;
        int         start_w;
    } txn_t;

    logic        CLK, RST;
    logic [2:0]  req, req_we, gnt, done;
    logic [23:0] req_addr, req_wdata;
    logic        err, eng_start, eng_we, eng_done, busy;
    logic [7:0]  rdata, eng_addr, eng_wdata, eng_rdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    txn_t sb[$];
    txn_t vecs[7];

    int   eng_lat = 0;
    int   eng_k   = 0;
    logic eng_done_m = 1'b0;
    logic spur = 1'b0;

    rtc_bus_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .eng_start (eng_start),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_done  (eng_done),
        .eng_rdata (eng_rdata),
        .busy      (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Engine model: read data is a fixed function of the address it was handed.
    assign eng_rdata = eng_addr ^ 8'h78;
    assign eng_done  = eng_done_m | spur;

    always @(negedge CLK) begin
        if (|gnt) begin
            eng_k      = eng_k + 1;
            eng_done_m = (eng_k == eng_lat);
        end else begin
            eng_k      = 0;
            eng_done_m = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input int idx, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input int lat, input logic [7:0] rd,
                                input logic e, input int dl, input int sw);
        txn_t t;
        t.idx = idx; t.we = we; t.addr = addr; t.wdata = wdata; t.lat = lat;
        t.rdata = rd; t.err = e; t.done_lat = dl; t.start_w = sw;
        return t;
    endfunction

    // Scoreboard monitor: grant rise checks the latched command, done pops the result.
    int   cyc = 0, last_done = 0, tr_cyc = 0, start_cnt = 0;
    bit   in_tr = 0, have_done = 0;
    logic [2:0] prev_gnt = '0;
    always @(negedge CLK) begin
        txn_t e;
        cyc++;
        if (RST) begin
            in_tr     = 0;
            have_done = 0;
        end else begin
            if (gnt != 3'b000 && prev_gnt == 3'b000) begin
                check("gnt_onehot", $onehot(gnt), 1);
                if (have_done) check("gap_respected", (cyc - last_done) >= GAP_CYC + 1, 1);
                if (sb.size() == 0) check("grant_unexpected", gnt, 0);
                else begin
                    e = sb[0];
                    check("gnt_idx", gnt, 3'b001 << e.idx);
                    check("eng_we", eng_we, e.we);
                    check("eng_addr", eng_addr, e.addr);
                    check("eng_wdata", eng_wdata, e.wdata);
                end
                in_tr = 1; tr_cyc = 0; start_cnt = 0;
            end
            if (in_tr) begin
                tr_cyc++;
                if (eng_start) start_cnt++;
            end
            if (done != 3'b000) begin
                if (sb.size() == 0) check("done_unexpected", done, 0);
                else begin
                    e = sb.pop_front();
                    check("done_idx", done, 3'b001 << e.idx);
                    check("err", err, e.err);
                    check("rdata", rdata, e.rdata);
                    check("done_latency", tr_cyc - 1, e.done_lat);
                    check("start_width", start_cnt, e.start_w);
                end
                in_tr = 0; have_done = 1; last_done = cyc;
            end
        end
        prev_gnt = gnt;
    end

    task automatic drive_req(input txn_t t);
        eng_lat = t.lat;
        req_we[t.idx] = t.we;
        req_addr[t.idx*8 +: 8] = t.addr;
        req_wdata[t.idx*8 +: 8] = t.wdata;
        req[t.idx] = 1'b1;
        sb.push_back(t);
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            if (|done) seen = 1;
        end
        check("done_within_bound", seen, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge CLK);
            if (!busy) seen = 1;
        end
        check("idle_within_bound", seen, 1);
    endtask

    initial begin
        txn_t a, b;
        //            idx we addr   wdata lat  rdata  err dlat start
        vecs[0] = mk(1, 0, 8'h21, 8'h00, 5,   8'h59, 0, 5,   5);
        vecs[1] = mk(0, 1, 8'h0A, 8'h5C, 2,   8'h59, 0, 2,   2);
        vecs[2] = mk(2, 0, 8'h3C, 8'h00, 1,   8'h44, 0, 1,   1);
        vecs[3] = mk(2, 1, 8'h05, 8'hAA, 8,   8'h44, 0, 8,   8);
        vecs[4] = mk(1, 0, 8'h7F, 8'h00, 12,  8'h07, 0, 12,  8);
        vecs[5] = mk(0, 0, 8'hF0, 8'h00, 255, 8'h88, 0, 255, 8);
        vecs[6] = mk(1, 0, 8'h10, 8'h00, 0,   8'h88, 1, 255, 8);

        RST = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        @(negedge CLK);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_we", eng_we, 0);
        check("rst_eng_addr", eng_addr, 0);
        check("rst_eng_wdata", eng_wdata, 0);
        check("rst_busy", busy, 0);
        #2 RST = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(negedge CLK);
            drive_req(vecs[v]);
            wait_done(400);
            req[vecs[v].idx] = 1'b0;
            wait_idle(20);
        end

        // Priority: init requester beats requester 2 presented in the same cycle.
        @(negedge CLK);
        a = mk(0, 1, 8'h02, 8'h10, 3, 8'h88, 0, 3, 3);
        b = mk(2, 0, 8'h30, 8'h00, 3, 8'h48, 0, 3, 3);
        drive_req(a);
        drive_req(b);
        wait_done(50);
        req[0] = 1'b0;
        wait_done(50);
        req[2] = 1'b0;
        wait_idle(20);

        // Round-robin between two continuously held requesters.
        @(negedge CLK);
        a = mk(1, 0, 8'h11, 8'h00, 3, 8'h69, 0, 3, 3);
        b = mk(2, 0, 8'h22, 8'h00, 3, 8'h5A, 0, 3, 3);
        drive_req(a);
        drive_req(b);
        sb.push_back(a);
        sb.push_back(b);
        for (int i = 0; i < 4; i++) wait_done(50);
        req[1] = 1'b0;
        req[2] = 1'b0;
        wait_idle(20);

        // Input freeze during WAIT, then spurious eng_done in GAP and IDLE.
        @(negedge CLK);
        drive_req(mk(1, 0, 8'h21, 8'h00, 20, 8'h59, 0, 20, 8));
        repeat (12) @(negedge CLK);
        check("freeze_in_wait", {busy, eng_start}, 2'b10);
        req_addr[15:8] = 8'h44;
        req[1] = 1'b0;
        @(negedge CLK);
        check("freeze_eng_addr", eng_addr, 8'h21);
        wait_done(50);
        spur = 1'b1;
        @(negedge CLK);
        spur = 1'b0;
        check("spur_gap_done", done, 0);
        check("spur_gap_gnt", gnt, 0);
        wait_idle(20);
        spur = 1'b1;
        @(negedge CLK);
        spur = 1'b0;
        check("spur_idle_done", done, 0);
        check("spur_idle_busy", busy, 0);

        // Asynchronous reset while waiting on the engine.
        @(negedge CLK);
        drive_req(mk(2, 0, 8'h33, 8'h00, 0, 8'h00, 0, 0, 0));
        repeat (15) @(negedge CLK);
        check("pre_rst_busy", busy, 1);
        #2 RST = 1'b1;
        req[2] = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_eng_start", eng_start, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        sb.delete();
        @(negedge CLK);
        #2 RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("post_rst_done", done, 0);
        check("post_rst_rdata", rdata, 0);
        drive_req(mk(1, 0, 8'h21, 8'h00, 4, 8'h59, 0, 4, 4));
        wait_done(50);
        req[1] = 1'b0;
        wait_idle(20);

        repeat (3) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the single RTC read/write engine between N requesters: init sequencer, periodic sweep/menu FSM, timer/alarm service.
- Each requester presents one transaction: address, write enable, write data.
- The arbiter picks a winner, drives the engine's start/done handshake, returns read data and a completion pulse.
- It also enforces a minimum idle gap between engine transactions. Sits between the menu/control FSMs and the RTC bus-timing engine.

Parameters:
- N_REQ, 3, number of requesters; index 0 has absolute priority (init), 1..N_REQ-1 round-robin.
- ADDR_W, 8, RTC address width.
- DATA_W, 8, RTC data width.
- START_MAX, 8, maximum cycles eng_start is held high per transaction.
- GAP_CYC, 4, idle cycles forced between consecutive transactions (1..255).
- TIMEOUT, 255, cycles waited for eng_done before abort (≥ START_MAX).

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- req  in  N_REQ  per-requester request level
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data
- gnt  out  N_REQ  one-hot grant, held for the whole transaction
- done  out  N_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse coincident with done when the transaction timed out
- rdata  out  DATA_W  read data, valid from the done cycle until the next done
- eng_start  out  1  start/access strobe to the engine
- eng_we  out  1  latched write enable
- eng_addr  out  ADDR_W  latched address
- eng_wdata  out  DATA_W  latched write data
- eng_done  in  1  engine finished (one-cycle pulse)
- eng_rdata  in  DATA_W  engine read data, valid with eng_done
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer = 1, all counters 0.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- IDLE:
  - If req[0], the winner is 0.
  - Otherwise the winner is the first asserted req at or after the rr pointer among 1..N_REQ-1, with wrap.
  - On a winner: latch we/addr/wdata into eng_* and go to ISSUE. gnt[winner] rises in the same clock edge (registered).
  - With no requests, stay in IDLE.
- ISSUE:
  - eng_start = 1.
  - Count cycles. After START_MAX cycles in ISSUE, drop eng_start and go to WAIT.
  - If eng_done arrives while in ISSUE, take the completion path directly.
- WAIT:
  - eng_start = 0. The timeout counter runs from entry to ISSUE.
  - eng_done → completion.
  - Counter reaches TIMEOUT → completion with err = 1; rdata is not updated.
- Completion, a single clock edge:
  - done[g] = 1 for one cycle; rdata <= eng_rdata on reads only (writes leave rdata unchanged).
  - gnt cleared; eng_start cleared; go to GAP.
  - If g ≠ 0, the rr pointer advances to g+1, wrapping to 1.
- GAP: hold GAP_CYC cycles with no grant, then go to IDLE. Arbitration happens only in IDLE.
- Latency: req in IDLE → eng_start high is 1 cycle. eng_done → done pulse is 1 cycle (registered).
- Latched command is frozen: req/addr/data changes during ISSUE/WAIT are ignored. If req drops mid-transaction, the transaction still completes and done still pulses.
- eng_done seen in IDLE or GAP is ignored (spurious).
- Simultaneous eng_done and the timeout terminal count: eng_done wins, err = 0.
- A requester that holds req through its own done is eligible again after GAP (req[0] can monopolise; this is intended for init).
- RST asserted mid-transaction: all outputs drop asynchronously, no done pulse. The engine is expected to be reset by the same RST.
- Counters are sized $clog2(max(START_MAX, TIMEOUT, GAP_CYC) + 1) and saturate, with no wrap.

Decomposition:
- Package rtc_bus_pkg: FSM state enum (IDLE/ISSUE/WAIT/GAP), default ADDR_W/DATA_W, RTC command address constant 8'hF0.
- One sub-module: rtc_rr_pick (combinational round-robin priority picker over N_REQ-1 lines with pointer input and one-hot output). Instantiate it once.
- The FSM, counters and latches stay in the top module.

Test Plan:
- Single read: req[1]=1, we=0, addr=8'h21; engine returns eng_done after 5 cycles with 8'h59 → eng_start high 5 cycles, done[1] pulse, rdata=8'h59, next grant ≥ GAP_CYC+1 cycles later.
- Priority: req[0] (write 8'h02 ← 8'h10) and req[2] asserted in the same cycle → gnt[0] first with eng_we=1, eng_addr=8'h02, eng_wdata=8'h10; gnt[2] only after GAP.
- Round-robin: req[1] and req[2] held continuously, engine done in 3 cycles → grant order 1, 2, 1, 2; never two consecutive grants to the same index.
- Timeout: eng_done never asserted → eng_start falls after 8 cycles, done+err pulse at cycle 255, rdata unchanged, FSM returns to IDLE after GAP.
- Input freeze: change req_addr[1] from 8'h21 to 8'h44 and drop req[1] during WAIT → eng_addr stays 8'h21, done[1] still pulses.
- Async reset in WAIT: pulse RST mid-cycle → gnt, eng_start, busy = 0 immediately, no done pulse, next request served normally.
